// File: rtl/hash_rs_pkg.sv
// hash_rs shared types and defaults.
// Entry and issue bundles for the hash reservation station.
package hash_rs_pkg;

  localparam int RS_DEPTH = 4;
  localparam int DATA_W   = 8;
  localparam int TAG_W    = 4;
  localparam int NDEPS    = 2;

  typedef struct packed {
    logic                             valid;
    logic [DATA_W-1:0]                operand;
    logic [NDEPS-1:0][DATA_W-1:0]     depvals;
    logic [NDEPS-1:0]                 dep_ready;
    logic [NDEPS-1:0][TAG_W-1:0]      dep_tag;
    logic [DATA_W-1:0]                wbs;
    logic [DATA_W-1:0]                flags;
    logic [TAG_W-1:0]                 robid;
  } rs_entry_t;

  typedef struct packed {
    logic [DATA_W-1:0]                operand;
    logic [NDEPS-1:0][DATA_W-1:0]     depvals;
    logic [DATA_W-1:0]                wbs;
    logic [DATA_W-1:0]                flags;
    logic [TAG_W-1:0]                 robid;
  } issue_t;

endpackage

// File: rtl/hash_rs_if.sv
// hash_rs dispatch, CDB and FU issue bus.
// slave = reservation station, master = surrounding pipeline.
interface hash_rs_if;
  import hash_rs_pkg::*;

  logic                    flush;
  logic                    disp_valid;
  logic                    disp_ready;
  logic [DATA_W-1:0]       disp_operand;
  logic [NDEPS*DATA_W-1:0] disp_depvals;
  logic [NDEPS-1:0]        disp_dep_ready;
  logic [NDEPS*TAG_W-1:0]  disp_dep_tag;
  logic [DATA_W-1:0]       disp_wbs;
  logic [DATA_W-1:0]       disp_flags;
  logic [TAG_W-1:0]        disp_robid;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_id;
  logic [DATA_W-1:0]       cdb_val;
  logic                    fu_busy;
  logic                    issue_transmit;
  logic [DATA_W-1:0]       issue_operand;
  logic [NDEPS*DATA_W-1:0] issue_depvals;
  logic [DATA_W-1:0]       issue_wbs;
  logic [DATA_W-1:0]       issue_flags;
  logic [TAG_W-1:0]        issue_robid;

  modport slave (
    input  flush, disp_valid, disp_operand, disp_depvals,
    input  disp_dep_ready, disp_dep_tag, disp_wbs, disp_flags,
    input  disp_robid, cdb_valid, cdb_id, cdb_val, fu_busy,
    output disp_ready, issue_transmit, issue_operand,
    output issue_depvals, issue_wbs, issue_flags, issue_robid
  );

  modport master (
    output flush, disp_valid, disp_operand, disp_depvals,
    output disp_dep_ready, disp_dep_tag, disp_wbs, disp_flags,
    output disp_robid, cdb_valid, cdb_id, cdb_val, fu_busy,
    input  disp_ready, issue_transmit, issue_operand,
    input  issue_depvals, issue_wbs, issue_flags, issue_robid
  );

endinterface

// File: rtl/hash_rs_wakeup.sv
// rs_wakeup: one entry's CDB tag compare and value capture.
// Only valid entries with a still-pending source are touched.
module rs_wakeup
  import hash_rs_pkg::*;
(
  input  rs_entry_t         ent_i,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_id,
  input  logic [DATA_W-1:0] cdb_val,
  output rs_entry_t         ent_o
);

  // capture broadcast value into every matching pending source
  always_comb begin
    ent_o = ent_i;
    for (int d = 0; d < NDEPS; d++) begin
      if (ent_i.valid && !ent_i.dep_ready[d] && cdb_valid &&
          ent_i.dep_tag[d] == cdb_id) begin
        ent_o.dep_ready[d] = 1'b1;
        ent_o.depvals[d]   = cdb_val;
      end
    end
  end

endmodule

// File: rtl/hash_rs.sv
// hash_rs: collapsing reservation station feeding the hash FU.
// Slot 0 is oldest; oldest ready entry issues when FU is free.
module hash_rs
  import hash_rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input logic       clk,
  input logic       rst,
  hash_rs_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t        ent_q   [DEPTH];
  rs_entry_t        ent_d   [DEPTH];
  rs_entry_t        woken   [DEPTH];
  rs_entry_t        shifted [DEPTH];
  rs_entry_t        new_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_mid;
  issue_t           iss_q;
  issue_t           iss_d;
  logic             tx_q;
  logic             tx_d;
  logic [IDX_W-1:0] sel;
  logic             has_sel;
  logic             do_issue;
  logic             do_disp;

  for (genvar i = 0; i < DEPTH; i++) begin : g_wk
    rs_wakeup u_wk (
      .ent_i     (ent_q[i]),
      .cdb_valid (bus.cdb_valid),
      .cdb_id    (bus.cdb_id),
      .cdb_val   (bus.cdb_val),
      .ent_o     (woken[i])
    );
  end

  assign bus.disp_ready     = (count_q < CNT_W'(DEPTH));
  assign bus.issue_transmit = tx_q;
  assign bus.issue_operand  = iss_q.operand;
  assign bus.issue_depvals  = iss_q.depvals;
  assign bus.issue_wbs      = iss_q.wbs;
  assign bus.issue_flags    = iss_q.flags;
  assign bus.issue_robid    = iss_q.robid;

  // oldest fully-ready entry, from registered state only
  always_comb begin
    has_sel = 1'b0;
    sel     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && (&ent_q[i].dep_ready)) begin
        has_sel = 1'b1;
        sel     = IDX_W'(i);
      end
    end
  end

  // incoming op, with same-cycle CDB bypass on pending sources
  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.operand   = bus.disp_operand;
    new_ent.depvals   = bus.disp_depvals;
    new_ent.dep_ready = bus.disp_dep_ready;
    new_ent.dep_tag   = bus.disp_dep_tag;
    new_ent.wbs       = bus.disp_wbs;
    new_ent.flags     = bus.disp_flags;
    new_ent.robid     = bus.disp_robid;
    for (int d = 0; d < NDEPS; d++) begin
      if (!bus.disp_dep_ready[d] && bus.cdb_valid &&
          bus.disp_dep_tag[d*TAG_W +: TAG_W] == bus.cdb_id) begin
        new_ent.dep_ready[d] = 1'b1;
        new_ent.depvals[d]   = bus.cdb_val;
      end
    end
  end

  // collapse on issue, append on dispatch, flush wins
  always_comb begin
    do_issue = has_sel && !bus.fu_busy;
    do_disp  = bus.disp_valid && bus.disp_ready;
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = woken[i + 1];
    end
    shifted[DEPTH-1] = '0;
    count_mid = count_q - CNT_W'(do_issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && i >= int'(sel)) begin
        ent_d[i] = shifted[i];
      end else begin
        ent_d[i] = woken[i];
      end
      if (do_disp && CNT_W'(i) == count_mid) begin
        ent_d[i] = new_ent;
      end
    end
    count_d = count_mid + CNT_W'(do_disp);
    tx_d    = do_issue;
    iss_d   = iss_q;
    if (do_issue) begin
      iss_d.operand = ent_q[sel].operand;
      iss_d.depvals = ent_q[sel].depvals;
      iss_d.wbs     = ent_q[sel].wbs;
      iss_d.flags   = ent_q[sel].flags;
      iss_d.robid   = ent_q[sel].robid;
    end
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
      count_d = '0;
      tx_d    = 1'b0;
      iss_d   = iss_q;
    end
  end

  // state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
      iss_q   <= '0;
      tx_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
      iss_q   <= iss_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_hash_rs.sv
// tb_hash_rs: scoreboard bench for the hash reservation station.
// Directed ops push expectations; a negedge monitor checks issues.
module tb_hash_rs;

  typedef struct {
    logic [3:0] rid;
    logic [7:0] d0;
    logic [7:0] d1;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  int   acc;
  exp_t q[$];

  hash_rs_if bus ();

  hash_rs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [43:0] pack_exp(input exp_t e);
    logic [7:0] r8;
    r8 = {4'h0, e.rid};
    return {8'h40 + r8, e.d1, e.d0, 8'h80 | r8, 8'hF0 ^ r8, e.rid};
  endfunction

  // monitor: every transmit pulse must match the queue head
  always @(negedge clk) begin
    if (bus.issue_transmit) begin
      logic [43:0] act;
      logic [43:0] want;
      exp_t e;
      tot_cnt++;
      act = {bus.issue_operand, bus.issue_depvals, bus.issue_wbs,
             bus.issue_flags, bus.issue_robid};
      if (q.size() == 0) begin
        $display("FAIL unexpected_issue cyc=%0d got=%h", cyc, act);
      end else begin
        e = q.pop_front();
        want = pack_exp(e);
        if (act === want && cyc == e.cyc) pass_cnt++;
        else $display("FAIL issue rid=%0d got=%h@%0d want=%h@%0d",
                      e.rid, act, cyc, want, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    tot_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", name, act, want);
  endtask

  task automatic disp(input logic [3:0] rid, input logic [7:0] d0,
                      input logic [7:0] d1, input logic [1:0] rdy,
                      input logic [3:0] t0, input logic [3:0] t1,
                      output int a);
    bus.disp_valid     = 1'b1;
    bus.disp_operand   = 8'h40 + {4'h0, rid};
    bus.disp_depvals   = {d1, d0};
    bus.disp_dep_ready = rdy;
    bus.disp_dep_tag   = {t1, t0};
    bus.disp_wbs       = 8'h80 | {4'h0, rid};
    bus.disp_flags     = 8'hF0 ^ {4'h0, rid};
    bus.disp_robid     = rid;
    tick();
    a = cyc;
    bus.disp_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] rid, input logic [7:0] d0,
                      input logic [7:0] d1, input int c);
    exp_t e;
    e.rid = rid;
    e.d0  = d0;
    e.d1  = d1;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    repeat (3) tick();
    tot_cnt++;
    if (q.size() == 0) pass_cnt++;
    else begin
      $display("FAIL drain_%s pending=%0d want=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic cdb(input logic [3:0] id, input logic [7:0] v);
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = id;
    bus.cdb_val   = v;
    tick();
    bus.cdb_valid = 1'b0;
  endtask

  initial begin
    bus.flush          = 1'b0;
    bus.disp_valid     = 1'b0;
    bus.disp_operand   = '0;
    bus.disp_depvals   = '0;
    bus.disp_dep_ready = '0;
    bus.disp_dep_tag   = '0;
    bus.disp_wbs       = '0;
    bus.disp_flags     = '0;
    bus.disp_robid     = '0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_id         = '0;
    bus.cdb_val        = '0;
    bus.fu_busy        = 1'b0;

    repeat (2) tick();
    rst = 1'b0;
    chk("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
    chk("rst_transmit", 32'(bus.issue_transmit), 32'd0);
    chk("rst_operand", 32'(bus.issue_operand), 32'd0);
    chk("rst_depvals", 32'(bus.issue_depvals), 32'd0);
    chk("rst_wbs_flags", 32'({bus.issue_wbs, bus.issue_flags}), 32'd0);
    chk("rst_robid", 32'(bus.issue_robid), 32'd0);

    // ready op issues one edge after dispatch
    disp(4'd3, 8'h12, 8'h34, 2'b11, 4'd0, 4'd0, acc);
    push(4'd3, 8'h12, 8'h34, acc + 1);
    drain("ready");

    // pending dep0 woken three cycles later
    disp(4'd4, 8'h00, 8'h33, 2'b10, 4'd5, 4'd0, acc);
    repeat (2) tick();
    cdb(4'd5, 8'hA7);
    push(4'd4, 8'hA7, 8'h33, cyc + 1);
    drain("wakeup");

    // bypass: CDB match in the dispatch cycle
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = 4'd5;
    bus.cdb_val   = 8'h5C;
    disp(4'd6, 8'h00, 8'h66, 2'b10, 4'd5, 4'd0, acc);
    bus.cdb_valid = 1'b0;
    push(4'd6, 8'h5C, 8'h66, acc + 1);
    drain("bypass");

    // fill with FU stalled, overflow op ignored
    bus.fu_busy = 1'b1;
    for (int i = 8; i < 12; i++) begin
      disp(4'(i), 8'(i * 3), 8'(i * 5), 2'b11, 4'd0, 4'd0, acc);
    end
    chk("full_not_ready", 32'(bus.disp_ready), 32'd0);
    disp(4'd12, 8'hEE, 8'hEE, 2'b11, 4'd0, 4'd0, acc);
    chk("full_still", 32'(bus.disp_ready), 32'd0);
    bus.fu_busy = 1'b0;
    for (int i = 8; i < 12; i++) begin
      push(4'(i), 8'(i * 3), 8'(i * 5), cyc + i - 7);
    end
    drain("full");
    chk("empty_ready", 32'(bus.disp_ready), 32'd1);

    // younger ready op passes older pending op
    disp(4'd1, 8'h00, 8'h11, 2'b10, 4'd7, 4'd0, acc);
    disp(4'd2, 8'h22, 8'h23, 2'b11, 4'd0, 4'd0, acc);
    push(4'd2, 8'h22, 8'h23, acc + 1);
    repeat (2) tick();
    cdb(4'd7, 8'h77);
    push(4'd1, 8'h77, 8'h11, cyc + 1);
    drain("ooo");

    // flush a full queue together with a dispatch
    bus.fu_busy = 1'b1;
    for (int i = 1; i < 5; i++) begin
      disp(4'(i), 8'(i), 8'(i + 16), 2'b11, 4'd0, 4'd0, acc);
    end
    chk("flush_pre_full", 32'(bus.disp_ready), 32'd0);
    bus.flush   = 1'b1;
    bus.fu_busy = 1'b0;
    disp(4'd5, 8'h55, 8'h55, 2'b11, 4'd0, 4'd0, acc);
    bus.flush = 1'b0;
    chk("flush_ready", 32'(bus.disp_ready), 32'd1);
    chk("flush_no_tx", 32'(bus.issue_transmit), 32'd0);
    repeat (6) tick();
    disp(4'd13, 8'hD1, 8'hD2, 2'b11, 4'd0, 4'd0, acc);
    push(4'd13, 8'hD1, 8'hD2, acc + 1);
    drain("flush");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
